// File: rtl/jtag_pkg.sv
// Shared TAP state encoding and instruction opcodes.
package jtag_pkg;

    // 1149.1 encoding with TEST_LOGIC_RESET and EXIT2_DR swapped so the
    // reset state reads as 4'h0 on the debug port.
    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'h0,
        RUN_TEST_IDLE    = 4'hC,
        SELECT_DR        = 4'h7,
        CAPTURE_DR       = 4'h6,
        SHIFT_DR         = 4'h2,
        EXIT1_DR         = 4'h1,
        PAUSE_DR         = 4'h3,
        EXIT2_DR         = 4'hF,
        UPDATE_DR        = 4'h5,
        SELECT_IR        = 4'h4,
        CAPTURE_IR       = 4'hE,
        SHIFT_IR         = 4'hA,
        EXIT1_IR         = 4'h9,
        PAUSE_IR         = 4'hB,
        EXIT2_IR         = 4'h8,
        UPDATE_IR        = 4'hD
    } tap_state_t;

    localparam logic [3:0] INS_IDCODE = 4'h6;
    localparam logic [3:0] INS_USER   = 4'h2;
    localparam logic [3:0] INS_BYPASS = 4'hF;

    // Which data register the current instruction selects
    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_t;

endpackage

// File: rtl/jtag_in_sync.sv
// Two-flop synchronizers for TCK/TMS/TDI plus TCK edge detection.
module jtag_in_sync (
    input  logic CLK,
    input  logic RESETn,
    input  logic TCK,
    input  logic TMS,
    input  logic TDI,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_s,
    output logic tdi_s
);

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic       tck_prev;

    // Bit 2 = TCK, bit 1 = TMS, bit 0 = TDI; all three move in lockstep so
    // TMS/TDI are sampled from the same stage as the TCK edge.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            sync1    <= '0;
            sync2    <= '0;
            tck_prev <= 1'b0;
        end else begin
            sync1    <= {TCK, TMS, TDI};
            sync2    <= sync1;
            tck_prev <= sync2[2];
        end
    end

    assign tck_rise = sync2[2] & ~tck_prev;
    assign tck_fall = ~sync2[2] & tck_prev;
    assign tms_s    = sync2[1];
    assign tdi_s    = sync2[0];

endmodule

// File: rtl/jtag_tap_responder.sv
// JTAG target TAP: oversampled TAP FSM with IR, IDCODE, BYPASS and a
// fabric-visible user data register.
module jtag_tap_responder
    import jtag_pkg::*;
#(
    parameter int          IR_LEN     = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h020F10DD,
    parameter int          USER_LEN   = 8
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                TCK,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_OE,
    input  logic [USER_LEN-1:0] user_dr_in,
    output logic [USER_LEN-1:0] user_dr_out,
    output logic                user_update,
    output logic [3:0]          tap_state,
    output logic                tlr
);

    logic tck_rise, tck_fall, tms_s, tdi_s;

    jtag_in_sync u_sync (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .TCK      (TCK),
        .TMS      (TMS),
        .TDI      (TDI),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tms_s    (tms_s),
        .tdi_s    (tdi_s)
    );

    tap_state_t          state, state_nxt;
    logic [IR_LEN-1:0]   ir, ir_shift;
    logic [31:0]         idcode_shift;
    logic [USER_LEN-1:0] user_shift;
    logic                bypass_shift;
    dr_sel_t             dr_sel;

    // Instruction decode; anything unrecognised behaves as BYPASS
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir == IR_LEN'(INS_IDCODE))    dr_sel = DR_IDCODE;
        else if (ir == IR_LEN'(INS_USER)) dr_sel = DR_USER;
    end

    // 1149.1 TAP next-state function on the synchronized TMS
    always_comb begin
        state_nxt = state;
        case (state)
            TEST_LOGIC_RESET: state_nxt = tms_s ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_nxt = tms_s ? SELECT_DR  : RUN_TEST_IDLE;
            SELECT_DR:        state_nxt = tms_s ? SELECT_IR  : CAPTURE_DR;
            CAPTURE_DR:       state_nxt = tms_s ? EXIT1_DR   : SHIFT_DR;
            SHIFT_DR:         state_nxt = tms_s ? EXIT1_DR   : SHIFT_DR;
            EXIT1_DR:         state_nxt = tms_s ? UPDATE_DR  : PAUSE_DR;
            PAUSE_DR:         state_nxt = tms_s ? EXIT2_DR   : PAUSE_DR;
            EXIT2_DR:         state_nxt = tms_s ? UPDATE_DR  : SHIFT_DR;
            UPDATE_DR:        state_nxt = tms_s ? SELECT_DR  : RUN_TEST_IDLE;
            SELECT_IR:        state_nxt = tms_s ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_nxt = tms_s ? EXIT1_IR   : SHIFT_IR;
            SHIFT_IR:         state_nxt = tms_s ? EXIT1_IR   : SHIFT_IR;
            EXIT1_IR:         state_nxt = tms_s ? UPDATE_IR  : PAUSE_IR;
            PAUSE_IR:         state_nxt = tms_s ? EXIT2_IR   : PAUSE_IR;
            EXIT2_IR:         state_nxt = tms_s ? UPDATE_IR  : SHIFT_IR;
            UPDATE_IR:        state_nxt = tms_s ? SELECT_DR  : RUN_TEST_IDLE;
            default:          state_nxt = TEST_LOGIC_RESET;
        endcase
    end

    // State register, capture/shift/update datapath and TDO launch
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state        <= TEST_LOGIC_RESET;
            ir           <= IR_LEN'(INS_IDCODE);
            ir_shift     <= '0;
            idcode_shift <= '0;
            user_shift   <= '0;
            bypass_shift <= 1'b0;
            user_dr_out  <= '0;
            user_update  <= 1'b0;
            TDO          <= 1'b0;
        end else begin
            user_update <= 1'b0;
            if (tck_rise) begin
                // Action keyed on the state being left
                case (state)
                    CAPTURE_DR: begin
                        case (dr_sel)
                            DR_IDCODE: idcode_shift <= IDCODE_VAL;
                            DR_USER:   user_shift   <= user_dr_in;
                            default:   bypass_shift <= 1'b0;
                        endcase
                    end
                    SHIFT_DR: begin
                        case (dr_sel)
                            DR_IDCODE: idcode_shift <= {tdi_s, idcode_shift[31:1]};
                            DR_USER:   user_shift   <= {tdi_s, user_shift[USER_LEN-1:1]};
                            default:   bypass_shift <= tdi_s;
                        endcase
                    end
                    CAPTURE_IR: ir_shift <= IR_LEN'(1);
                    SHIFT_IR:   ir_shift <= {tdi_s, ir_shift[IR_LEN-1:1]};
                    default: ;
                endcase

                state <= state_nxt;

                // Update actions fire on entry to the update state
                if (state_nxt == UPDATE_IR)
                    ir <= ir_shift;
                if (state_nxt == UPDATE_DR && dr_sel == DR_USER) begin
                    user_dr_out <= user_shift;
                    user_update <= 1'b1;
                end
                if (state_nxt == TEST_LOGIC_RESET)
                    ir <= IR_LEN'(INS_IDCODE);
            end

            // TDO changes only on the falling TCK edge so it is stable at the
            // master's next rising-edge sample.
            if (tck_fall) begin
                if (state == SHIFT_DR) begin
                    case (dr_sel)
                        DR_IDCODE: TDO <= idcode_shift[0];
                        DR_USER:   TDO <= user_shift[0];
                        default:   TDO <= bypass_shift;
                    endcase
                end else if (state == SHIFT_IR) begin
                    TDO <= ir_shift[0];
                end
            end
        end
    end

    assign TDO_OE    = (state == SHIFT_DR) || (state == SHIFT_IR);
    assign tap_state = state;
    assign tlr       = (state == TEST_LOGIC_RESET);

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench: drives the TAP pins like a JTAG master and checks scans.
module tb_jtag_tap_responder;

    logic       CLK = 1'b0;
    logic       RESETn;
    logic       TCK, TMS, TDI;
    logic       TDO, TDO_OE;
    logic [7:0] user_dr_in;
    logic [7:0] user_dr_out;
    logic       user_update;
    logic [3:0] tap_state;
    logic       tlr;

    int checks   = 0;
    int failures = 0;
    int upd_cnt  = 0;

    jtag_tap_responder #(
        .IR_LEN     (4),
        .IDCODE_VAL (32'h020F10DD),
        .USER_LEN   (8)
    ) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .TCK         (TCK),
        .TMS         (TMS),
        .TDI         (TDI),
        .TDO         (TDO),
        .TDO_OE      (TDO_OE),
        .user_dr_in  (user_dr_in),
        .user_dr_out (user_dr_out),
        .user_update (user_update),
        .tap_state   (tap_state),
        .tlr         (tlr)
    );

    always #5 CLK = ~CLK;

    // Count CLK cycles with user_update high (pulse width and count)
    always @(posedge CLK) if (user_update) upd_cnt <= upd_cnt + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    // One TCK period; TDO/TDO_OE sampled well after the falling edge
    task automatic tck_cyc(input logic tms, input logic tdi, output logic tdo, output logic oe);
        @(negedge CLK); TMS = tms; TDI = tdi;
        repeat (4) @(negedge CLK); TCK = 1'b1;
        repeat (4) @(negedge CLK); TCK = 1'b0;
        repeat (5) @(negedge CLK);
        tdo = TDO; oe = TDO_OE;
    endtask

    task automatic tck1(input logic tms, input logic tdi);
        logic d, o;
        tck_cyc(tms, tdi, d, o);
    endtask

    // Full IR or DR scan from RUN_TEST_IDLE back to RUN_TEST_IDLE, LSB first
    task automatic scan(input bit is_ir, input int n, input logic [31:0] din,
                        output logic [31:0] dout, output int oe_err);
        logic d, o;
        dout = '0; oe_err = 0;
        tck1(1'b1, 1'b0);                 // SELECT_DR
        if (is_ir) tck1(1'b1, 1'b0);      // SELECT_IR
        tck1(1'b0, 1'b0);                 // CAPTURE
        tck_cyc(1'b0, 1'b0, d, o);        // SHIFT, first bit out
        dout[0] = d;
        if (o !== 1'b1) oe_err++;
        for (int i = 0; i < n; i++) begin
            tck_cyc((i == n-1), din[i], d, o);
            if (i < n-1) dout[i+1] = d;
            if (o !== (i < n-1)) oe_err++;
        end
        tck1(1'b1, 1'b0);                 // UPDATE
        tck1(1'b0, 1'b0);                 // RUN_TEST_IDLE
    endtask

    initial begin
        logic [31:0] d;
        int          oe_err;
        int          upd0;

        RESETn = 1'b0; TCK = 1'b0; TMS = 1'b1; TDI = 1'b0;
        user_dr_in = 8'h3C;
        repeat (3) @(negedge CLK);
        chk("rst_state", 32'(tap_state), 32'h0);
        chk("rst_tlr",   32'(tlr), 32'h1);
        chk("rst_tdo",   32'(TDO), 32'h0);
        chk("rst_oe",    32'(TDO_OE), 32'h0);
        chk("rst_upd",   32'(user_update), 32'h0);
        chk("rst_udo",   32'(user_dr_out), 32'h0);
        RESETn = 1'b1;
        repeat (2) @(negedge CLK);

        // IDCODE is the default instruction
        tck1(1'b0, 1'b0);
        chk("rti_state", 32'(tap_state), 32'hC);
        chk("rti_oe",    32'(TDO_OE), 32'h0);
        scan(1'b0, 32, 32'h0, d, oe_err);
        chk("idcode", d, 32'h020F10DD);
        chk("idcode_oe", 32'(oe_err), 32'h0);
        chk("post_scan_state", 32'(tap_state), 32'hC);

        // IR capture value appears first on TDO
        scan(1'b1, 4, 32'h0, d, oe_err);
        chk("ir_capture", {28'h0, d[3:0]}, 32'h1);
        chk("ir_oe", 32'(oe_err), 32'h0);

        // BYPASS: one-bit delay with a leading 0
        scan(1'b1, 4, 32'hF, d, oe_err);
        scan(1'b0, 4, 32'hD, d, oe_err);
        chk("bypass", {28'h0, d[3:0]}, 32'hA);

        // USER scan interrupted by reset after 3 of 8 bits
        scan(1'b1, 4, 32'h2, d, oe_err);
        tck1(1'b1, 1'b0); tck1(1'b0, 1'b0); tck1(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tck1(1'b0, 1'b1);
        chk("pre_rst_tdo", 32'(TDO), 32'h1);
        upd0 = upd_cnt;
        @(negedge CLK); RESETn = 1'b0;
        repeat (2) @(negedge CLK);
        chk("mid_rst_state", 32'(tap_state), 32'h0);
        chk("mid_rst_tdo",   32'(TDO), 32'h0);
        chk("mid_rst_udo",   32'(user_dr_out), 32'h0);
        RESETn = 1'b1;
        repeat (2) @(negedge CLK);
        chk("mid_rst_noupd", 32'(upd_cnt - upd0), 32'h0);
        tck1(1'b0, 1'b0);

        // USER DR: capture 3C, update with A5, single pulse
        scan(1'b1, 4, 32'h2, d, oe_err);
        upd0 = upd_cnt;
        scan(1'b0, 8, 32'hA5, d, oe_err);
        chk("user_capture", {24'h0, d[7:0]}, 32'h3C);
        chk("user_oe", 32'(oe_err), 32'h0);
        chk("user_out", 32'(user_dr_out), 32'hA5);
        chk("user_pulses", 32'(upd_cnt - upd0), 32'h1);

        // Five TMS=1 from PAUSE_DR reach TEST_LOGIC_RESET and restore IDCODE
        scan(1'b1, 4, 32'hF, d, oe_err);
        tck1(1'b1, 1'b0); tck1(1'b0, 1'b0); tck1(1'b0, 1'b0);
        tck1(1'b1, 1'b0); tck1(1'b0, 1'b0);
        chk("pause_dr", 32'(tap_state), 32'h3);
        for (int i = 0; i < 5; i++) tck1(1'b1, 1'b0);
        chk("tms5_tlr",   32'(tlr), 32'h1);
        chk("tms5_state", 32'(tap_state), 32'h0);
        chk("tms5_udo",   32'(user_dr_out), 32'hA5);
        tck1(1'b0, 1'b0);
        scan(1'b0, 32, 32'h0, d, oe_err);
        chk("idcode_after_tlr", d, 32'h020F10DD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
